spimem_arbiter: RTL and testbench

SPIMEM_ARBITER -- requirements
Module: spimem_arbiter

---
 rtl/spimem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_spimem_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spimem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : spimem_arbiter
//  Description : Two-master round-robin read arbiter in front of a shared
//                SPI memory slave. Adds a guaranteed idle cycle between slave
//                transactions, a per-transaction timeout with error data, and
//                a sticky error flag that remembers the first failing address.
//  Revision    : 1.0 - initial release
// ============================================================================
module spimem_arbiter #(
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [31:0] ERR_RDATA      = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  input  logic        m1_valid,
  input  logic [23:0] m0_addr,
  input  logic [23:0] m1_addr,
  output logic        m0_ready,
  output logic        m1_ready,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic [23:0] s_addr,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  input  logic        err_clr,
  output logic        err,
  output logic [23:0] err_addr,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Counter value of the last BUSY cycle we are willing to wait.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      state_next;
  logic        last_grant;   // 0 = m0, 1 = m1; also the owner while BUSY/GAP
  logic [7:0]  tmo_cnt;

  logic        req_any;
  logic        pick;         // master chosen if a grant happens this cycle
  logic        owner_valid;  // request line of the master holding the slave
  logic        start;
  logic        abort;
  logic        done;
  logic        tmo;

  assign req_any     = m0_valid | m1_valid;
  // On a tie the master that was not served last wins; otherwise the asker.
  assign pick        = (m0_valid & m1_valid) ? ~last_grant : m1_valid;
  assign owner_valid = last_grant ? m1_valid : m0_valid;

  assign s_valid     = (state == BUSY);
  assign busy        = (state != IDLE);

  // Next-state and transaction-event decode.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    abort      = 1'b0;
    done       = 1'b0;
    tmo        = 1'b0;
    case (state)
      IDLE: begin
        if (req_any) begin
          start      = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        // A withdrawn request beats everything; a late s_ready beats timeout.
        if (!owner_valid) begin
          abort      = 1'b1;
          state_next = GAP;
        end else if (s_ready) begin
          done       = 1'b1;
          state_next = GAP;
        end else if (tmo_cnt == TMO_LAST) begin
          tmo        = 1'b1;
          state_next = GAP;
        end
      end
      GAP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Grant bookkeeping and the registered slave address.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant <= 1'b1;
      s_addr     <= 24'h000000;
    end else if (start) begin
      last_grant <= pick;
      s_addr     <= pick ? m1_addr : m0_addr;
    end
  end

  // Timeout counter: cleared on grant, counts BUSY cycles without s_ready.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tmo_cnt <= 8'd0;
    end else if (start) begin
      tmo_cnt <= 8'd0;
    end else if (state == BUSY && !s_ready) begin
      tmo_cnt <= tmo_cnt + 8'd1;
    end
  end

  // Completion pulses and per-master read data (held between completions).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m0_ready <= 1'b0;
      m1_ready <= 1'b0;
      m0_rdata <= 32'h0000_0000;
      m1_rdata <= 32'h0000_0000;
    end else begin
      m0_ready <= 1'b0;
      m1_ready <= 1'b0;
      if (done || tmo) begin
        if (last_grant) begin
          m1_ready <= 1'b1;
          m1_rdata <= done ? s_rdata : ERR_RDATA;
        end else begin
          m0_ready <= 1'b1;
          m0_rdata <= done ? s_rdata : ERR_RDATA;
        end
      end
    end
  end

  // Sticky error flag; a timeout in the same cycle as err_clr keeps it set.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err <= 1'b0;
    end else if (tmo) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

  // First failing address: only captured while no error is outstanding.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_addr <= 24'h000000;
    end else if (tmo && !err) begin
      err_addr <= s_addr;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spimem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spimem_arbiter
//  Description : Scoreboard bench for spimem_arbiter. Stimulus pushes the
//                expected completion (master, address, data, BUSY length);
//                a monitor pops and compares whenever a ready pulse appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spimem_arbiter;

  localparam int          TMO = 8;
  localparam logic [31:0] ERR = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m0_valid, m1_valid;
  logic [23:0] m0_addr, m1_addr;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid;
  logic [23:0] s_addr;
  logic        s_ready;
  logic [31:0] s_rdata;
  logic        err_clr;
  logic        err;
  logic [23:0] err_addr;
  logic        busy;

  spimem_arbiter #(.TIMEOUT_CYCLES(TMO), .ERR_RDATA(ERR)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m1_valid(m1_valid),
    .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_ready(m0_ready), .m1_ready(m1_ready),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_addr(s_addr),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .err_clr(err_clr), .err(err), .err_addr(err_addr), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        m;
    logic [23:0] addr;
    logic [31:0] data;
    logic [7:0]  cycles;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_m0_rdata = 32'h0;
  logic [31:0] exp_m1_rdata = 32'h0;

  int slave_lat    = 0;   // BUSY cycle in which s_ready rises; 0 = never
  bit slave_always = 1'b0; // s_ready held high regardless of state

  function automatic logic [31:0] slave_word(input logic [23:0] a);
    return (a == 24'h100010) ? 32'hDEADBEEF : {8'hA5, a};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic push(input logic m, input logic [23:0] a, input logic [31:0] d, input int c);
    exp_t e;
    e.m = m; e.addr = a; e.data = d; e.cycles = 8'(c);
    sb.push_back(e);
  endtask

  task automatic wait_ready(input logic m);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      if (m ? m1_ready : m0_ready) seen = 1'b1;
    end
    if (!seen) begin
      tests++; fails++;
      $display("FAIL ready_timeout: m%0d got no ready within 100 cycles", m);
    end
  endtask

  task automatic wait_any;
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      if (m0_ready || m1_ready) seen = 1'b1;
    end
    if (!seen) begin
      tests++; fails++;
      $display("FAIL ready_timeout: no ready from either master within 100 cycles");
    end
  endtask

  task automatic do_read(input logic m, input logic [23:0] a);
    if (m) begin m1_addr = a; m1_valid = 1'b1; end
    else   begin m0_addr = a; m0_valid = 1'b1; end
    wait_ready(m);
    @(posedge clk); #1;
    if (m) m1_valid = 1'b0; else m0_valid = 1'b0;
  endtask

  // Slave model: responds after slave_lat BUSY cycles (or always when forced).
  initial begin
    int sv_cnt;
    sv_cnt  = 0;
    s_ready = 1'b0;
    s_rdata = 32'h0BAD_0BAD;
    forever begin
      @(posedge clk); #1;
      if (slave_always) begin
        s_ready = 1'b1;
        s_rdata = s_valid ? slave_word(s_addr) : 32'h5A5A_5A5A;
      end else if (s_valid) begin
        sv_cnt++;
        s_ready = (slave_lat > 0) && (sv_cnt == slave_lat);
        s_rdata = s_ready ? slave_word(s_addr) : 32'h0BAD_0BAD;
      end else begin
        sv_cnt  = 0;
        s_ready = 1'b0;
        s_rdata = 32'h0BAD_0BAD;
      end
    end
  end

  // Monitor: every ready pulse must match the head of the scoreboard.
  initial begin
    exp_t e;
    int   run;
    bit   prev_sv;
    logic got_m;
    logic [31:0] got_d;
    run = 0;
    prev_sv = 1'b0;
    forever begin
      @(negedge clk);
      if (m0_ready || m1_ready) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_ready: m0_ready=%0b m1_ready=%0b, expected no completion",
                   m0_ready, m1_ready);
        end else begin
          e = sb.pop_front();
          got_m = m1_ready;
          got_d = m1_ready ? m1_rdata : m0_rdata;
          if ((m0_ready && m1_ready) || got_m != e.m || got_d !== e.data ||
              s_addr !== e.addr || s_valid !== 1'b0 || !prev_sv || run != int'(e.cycles)) begin
            fails++;
            $display("FAIL completion: got m%0d data=%h addr=%h busy_cycles=%0d s_valid=%0b, expected m%0d data=%h addr=%h busy_cycles=%0d s_valid=0",
                     got_m, got_d, s_addr, run, s_valid, e.m, e.data, e.addr, e.cycles);
          end
          if (e.m) exp_m1_rdata = e.data; else exp_m0_rdata = e.data;
        end
      end
      if (s_valid) run = prev_sv ? run + 1 : 1;
      prev_sv = s_valid;
    end
  end

  // Watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Directed stimulus.
  initial begin
    resetn = 1'b0; err_clr = 1'b0;
    m0_valid = 1'b0; m1_valid = 1'b0; m0_addr = 24'h0; m1_addr = 24'h0;

    // Reset state.
    repeat (3) @(posedge clk); #1;
    check("rst_s_valid", 32'(s_valid), 32'h0);
    check("rst_busy",    32'(busy),    32'h0);
    check("rst_err",     32'(err),     32'h0);
    check("rst_m0_rdata", m0_rdata,    32'h0);
    check("rst_s_addr",  32'(s_addr),  32'h0);
    resetn = 1'b1;

    // Both masters held: m0 wins the first tie, then strict alternation.
    slave_lat = 2;
    push(1'b0, 24'h000100, 32'hA500_0100, 2);
    push(1'b1, 24'h000200, 32'hA500_0200, 2);
    push(1'b0, 24'h000104, 32'hA500_0104, 2);
    push(1'b1, 24'h000204, 32'hA500_0204, 2);
    m0_addr = 24'h000100; m1_addr = 24'h000200;
    m0_valid = 1'b1; m1_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      wait_any();
      @(posedge clk); #1;
      case (k)
        1: m0_addr  = 24'h000104;
        2: m1_addr  = 24'h000204;
        3: m0_valid = 1'b0;
        default: m1_valid = 1'b0;
      endcase
    end

    // Single m0 read, slave answers in the 4th BUSY cycle.
    slave_lat = 4;
    push(1'b0, 24'h100010, 32'hDEADBEEF, 4);
    m0_addr = 24'h100010; m0_valid = 1'b1;
    @(negedge clk);
    check("req_s_valid_not_yet", 32'(s_valid), 32'h0);
    @(negedge clk);
    check("req_s_valid_1cyc", 32'(s_valid), 32'h1);
    check("req_s_addr", 32'(s_addr), 32'h0010_0010);
    wait_ready(1'b0);
    @(posedge clk); #1;
    m0_valid = 1'b0;
    check("single_err", 32'(err), 32'h0);

    // Timeout on m1 at address 0.
    slave_lat = 0;
    push(1'b1, 24'h000000, ERR, TMO);
    do_read(1'b1, 24'h000000);
    check("tmo1_err", 32'(err), 32'h1);
    check("tmo1_err_addr", 32'(err_addr), 32'h0);

    // Second timeout with err_clr in the final BUSY cycle: set wins, addr kept.
    push(1'b1, 24'h000040, ERR, TMO);
    m1_addr = 24'h000040; m1_valid = 1'b1;
    repeat (TMO) @(posedge clk);
    #1 err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    wait_ready(1'b1);
    check("tmo2_err_set_wins", 32'(err), 32'h1);
    check("tmo2_err_addr_kept", 32'(err_addr), 32'h0);
    @(posedge clk); #1;
    m1_valid = 1'b0;

    // err_clr takes effect one cycle later.
    err_clr = 1'b1;
    @(negedge clk);
    check("clr_not_yet", 32'(err), 32'h1);
    @(posedge clk); #1;
    err_clr = 1'b0;
    @(negedge clk);
    check("clr_done", 32'(err), 32'h0);
    @(posedge clk); #1;

    // s_ready in the final timeout cycle is a normal completion.
    slave_lat = TMO;
    push(1'b0, 24'h000080, 32'hA500_0080, TMO);
    do_read(1'b0, 24'h000080);
    check("late_ready_no_err", 32'(err), 32'h0);

    // Fresh timeout after clearing captures the new address.
    slave_lat = 0;
    push(1'b0, 24'h000300, ERR, TMO);
    do_read(1'b0, 24'h000300);
    check("tmo3_err", 32'(err), 32'h1);
    check("tmo3_err_addr", 32'(err_addr), 32'h0000_0300);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;

    // Granted m0 withdraws in BUSY cycle 2: abort, no ready, no error.
    m0_addr = 24'h000500; m0_valid = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    m0_valid = 1'b0;
    @(negedge clk);
    check("abort_still_busy", 32'(s_valid), 32'h1);
    @(negedge clk);
    check("abort_s_valid_low", 32'(s_valid), 32'h0);
    repeat (10) @(negedge clk);
    check("abort_m0_rdata", m0_rdata, exp_m0_rdata);
    check("abort_err", 32'(err), 32'h0);
    check("abort_idle", 32'(busy), 32'h0);
    @(posedge clk); #1;

    // s_ready high outside BUSY is ignored.
    slave_always = 1'b1;
    repeat (4) @(posedge clk); #1;
    check("idle_sready_m0_rdata", m0_rdata, exp_m0_rdata);
    check("idle_sready_m1_rdata", m1_rdata, exp_m1_rdata);
    push(1'b1, 24'h000123, 32'hA500_0123, 1);
    do_read(1'b1, 24'h000123);
    repeat (4) @(posedge clk); #1;
    slave_always = 1'b0;
    check("gap_sready_m1_rdata", m1_rdata, 32'hA500_0123);
    check("gap_sready_m0_rdata", m0_rdata, exp_m0_rdata);

    // Reset pulsed mid-BUSY with m1 pending.
    slave_lat = 0;
    m0_addr = 24'h000600; m0_valid = 1'b1;
    @(posedge clk); #1;
    m1_addr = 24'h000700; m1_valid = 1'b1;
    @(posedge clk); #3;
    resetn = 1'b0;
    #1;
    check("mid_rst_s_valid", 32'(s_valid), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_readies", {30'h0, m1_ready, m0_ready}, 32'h0);
    check("mid_rst_s_addr", 32'(s_addr), 32'h0);
    check("mid_rst_m0_rdata", m0_rdata, 32'h0);
    check("mid_rst_m1_rdata", m1_rdata, 32'h0);
    check("mid_rst_err_addr", 32'(err_addr), 32'h0);
    exp_m0_rdata = 32'h0;
    exp_m1_rdata = 32'h0;
    m0_valid = 1'b0;
    slave_lat = 2;
    push(1'b1, 24'h000700, 32'hA500_0700, 2);
    @(posedge clk); #1;
    resetn = 1'b1;
    wait_ready(1'b1);
    @(posedge clk); #1;
    m1_valid = 1'b0;

    repeat (5) @(posedge clk); #1;
    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
